// File: rtl/fft8_frame_seq.sv
// fft8_frame_seq
//   Stream-to-frame sequencer for fft8_core. Collects 8 complex samples from a
//   valid/ready stream into the core's flat input buses, pulses core_start,
//   waits for core_done, captures the 8 result bins and replays them in order
//   on a valid/ready output stream.
//   Optional feature: define FFT8_SEQ_TIMEOUT_EN to enable the WAIT watchdog
//   that drives err_timeout. Without it the core may take any number of cycles
//   and err_timeout is tied low.
module fft8_frame_seq #(
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_re,
    input  logic [DATA_W-1:0]   s_im,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_W-1:0]   m_re,
    output logic [DATA_W-1:0]   m_im,
    output logic [2:0]          m_idx,
    output logic                m_last,
    output logic                core_start,
    output logic [8*DATA_W-1:0] core_in_re_flat,
    output logic [8*DATA_W-1:0] core_in_im_flat,
    input  logic [8*DATA_W-1:0] core_out_re_flat,
    input  logic [8*DATA_W-1:0] core_out_im_flat,
    input  logic                core_done,
    output logic                busy,
    output logic                err_timeout
);

    // state    | meaning
    // ---------+-----------------------------------------------------------
    // S_LOAD   | accepting samples into lanes 0..7 (s_ready high)
    // S_START  | single-cycle core_start pulse, input lanes frozen
    // S_WAIT   | waiting for core_done; results captured when it arrives
    // S_UNLOAD | replaying bins 0..7 on the output stream

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_START  = 2'd1,
        S_WAIT   = 2'd2,
        S_UNLOAD = 2'd3
    } state_e;

    if (DATA_W < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("fft8_frame_seq: DATA_W and TIMEOUT_CYC must be at least 1");
    end

    state_e                     state_q;
    logic [2:0]                 wr_cnt_q;
    logic [2:0]                 rd_cnt_q;
    logic [2:0]                 wr_cnt_d;
    logic [2:0]                 rd_cnt_d;
    logic                       s_ready_q;
    logic                       m_valid_q;
    logic                       core_start_q;
    logic                       busy_q;

    logic [7:0][DATA_W-1:0]     in_re_q;
    logic [7:0][DATA_W-1:0]     in_im_q;
    logic [7:0][DATA_W-1:0]     out_re_q;
    logic [7:0][DATA_W-1:0]     out_im_q;

    logic                       in_acc;
    logic                       res_capture;
    logic                       wait_expired;

    // Counter increments; both wrap 7 -> 0 naturally in 3 bits.
    always_comb begin
        wr_cnt_d = wr_cnt_q + 3'd1;
        rd_cnt_d = rd_cnt_q + 3'd1;
    end

    // s_ready_q is only ever high in S_LOAD, so it alone qualifies an input accept.
    assign in_acc      = s_valid && s_ready_q;
    assign res_capture = (state_q == S_WAIT) && core_done;

`ifdef FFT8_SEQ_TIMEOUT_EN
    localparam int WCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYC - 1);

    logic [WCW-1:0] wait_cnt_q;
    logic           err_q;

    // wait_cnt_q holds the number of WAIT cycles already spent without done.
    assign wait_expired = (wait_cnt_q == WAIT_LAST);

    // Watchdog: counts WAIT cycles, latches the sticky error on expiry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (state_q == S_WAIT) begin
                wait_cnt_q <= wait_cnt_q + WCW'(1);
            end else begin
                wait_cnt_q <= '0;
            end
            if ((state_q == S_WAIT) && !core_done && wait_expired) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_timeout = err_q;
`else
    assign wait_expired = 1'b0;
    assign err_timeout  = 1'b0;
`endif

    // Frame sequencer: state, counters and registered handshake/control outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_LOAD;
            wr_cnt_q     <= 3'd0;
            rd_cnt_q     <= 3'd0;
            s_ready_q    <= 1'b1;
            m_valid_q    <= 1'b0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (in_acc) begin
                        wr_cnt_q <= wr_cnt_d;
                        if (wr_cnt_q == 3'd7) begin
                            state_q      <= S_START;
                            s_ready_q    <= 1'b0;
                            core_start_q <= 1'b1;
                            busy_q       <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        state_q   <= S_UNLOAD;
                        rd_cnt_q  <= 3'd0;
                        m_valid_q <= 1'b1;
                    end else if (wait_expired) begin
                        // Abandon the frame: nothing is emitted for it.
                        state_q   <= S_LOAD;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                S_UNLOAD: begin
                    if (m_ready) begin
                        if (rd_cnt_q == 3'd7) begin
                            state_q   <= S_LOAD;
                            rd_cnt_q  <= 3'd0;
                            m_valid_q <= 1'b0;
                            s_ready_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            rd_cnt_q <= rd_cnt_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    // Input lanes: written only on accepts, so they stay frozen through START/WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_re_q <= '0;
            in_im_q <= '0;
        end else if (in_acc) begin
            in_re_q[wr_cnt_q] <= s_re;
            in_im_q[wr_cnt_q] <= s_im;
        end
    end

    // Result buffer: all 16 lanes captured in the cycle done is seen in WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_re_q <= '0;
            out_im_q <= '0;
        end else if (res_capture) begin
            out_re_q <= core_out_re_flat;
            out_im_q <= core_out_im_flat;
        end
    end

    assign s_ready         = s_ready_q;
    assign m_valid         = m_valid_q;
    assign core_start      = core_start_q;
    assign busy            = busy_q;
    assign core_in_re_flat = in_re_q;
    assign core_in_im_flat = in_im_q;
    assign m_re            = out_re_q[rd_cnt_q];
    assign m_im            = out_im_q[rd_cnt_q];
    assign m_idx           = rd_cnt_q;
    assign m_last          = (rd_cnt_q == 3'd7);

endmodule

// File: tb/tb_fft8_frame_seq.sv
// Self-checking bench for fft8_frame_seq with a behavioural fft8_core stand-in.
// The core model issues fresh random bins on every start and raises done a
// fixed number of cycles later; the bench expects those bins back in order.
`timescale 1ns/1ps
module tb_fft8_frame_seq;
    localparam int W        = 16;
    localparam int TO       = 64;
    localparam int CORE_LAT = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           s_valid = 1'b0;
    logic           m_ready = 1'b1;
    logic           core_done = 1'b0;
    logic [W-1:0]   s_re = '0;
    logic [W-1:0]   s_im = '0;
    logic           s_ready, m_valid, m_last, core_start, busy, err_timeout;
    logic [W-1:0]   m_re, m_im;
    logic [2:0]     m_idx;
    logic [8*W-1:0] core_in_re_flat, core_in_im_flat;
    logic [8*W-1:0] core_out_re_flat = '0;
    logic [8*W-1:0] core_out_im_flat = '0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    fft8_frame_seq #(.DATA_W(W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im),
        .m_idx(m_idx), .m_last(m_last),
        .core_start(core_start),
        .core_in_re_flat(core_in_re_flat), .core_in_im_flat(core_in_im_flat),
        .core_out_re_flat(core_out_re_flat), .core_out_im_flat(core_out_im_flat),
        .core_done(core_done), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // core model: 0 = done pulse, 1 = done sticks high, 2 = never done
    int       core_mode = 0;
    bit       force_done = 1'b0;
    int       core_cnt = 0;
    int       done_cyc = -1;
    logic [W-1:0] exp_re[$], exp_im[$];

    // recorded activity
    int           n_start = 0;
    int           start_cyc_q[$];
    logic [W-1:0] cap_re[$], cap_im[$];
    int           n_acc = 0;
    int           last_acc_cyc = -1;
    logic [W-1:0] out_re_q[$], out_im_q[$];
    int           out_idx_q[$];
    bit           out_last_q[$];
    int           out_cyc_q[$];
    int           mv_rise_q[$];
    int           hold_viol = 0;
    int           inv_viol = 0;

    logic [W-1:0] tx_re[$], tx_im[$];
    int cosv[8] = '{32767, 23170, 0, -23170, -32767, -23170, 0, 23170};

    // Behavioural core: new random bins per start, done CORE_LAT cycles later.
    always @(negedge clk) begin
        if (!rst_n) begin
            core_done  = 1'b0;
            core_cnt   = 0;
            force_done = 1'b0;
        end else begin
            if (core_mode == 0 && core_done) core_done = 1'b0;
            if (core_start) begin
                for (int k = 0; k < 8; k++) begin
                    logic [W-1:0] br, bi;
                    br = W'($urandom);
                    bi = W'($urandom);
                    core_out_re_flat[k*W +: W] = br;
                    core_out_im_flat[k*W +: W] = bi;
                    exp_re.push_back(br);
                    exp_im.push_back(bi);
                end
                if (core_mode != 1) core_done = 1'b0;
                core_cnt = CORE_LAT;
            end else if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0 && core_mode != 2) begin
                    core_done = 1'b1;
                    done_cyc  = cyc;
                end
            end
            if (force_done) begin
                force_done = 1'b0;
                core_done  = 1'b1;
                done_cyc   = cyc;
            end
        end
    end

    // Activity recorder and protocol invariants, sampled mid-cycle.
    logic         prev_stall = 1'b0;
    logic         prev_mv = 1'b0;
    logic [W-1:0] prev_re, prev_im;
    logic [2:0]   prev_idx;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_mv    = 1'b0;
        end else begin
            if (s_valid && s_ready) begin
                n_acc++;
                last_acc_cyc = cyc;
            end
            if (core_start) begin
                n_start++;
                start_cyc_q.push_back(cyc);
                for (int k = 0; k < 8; k++) begin
                    cap_re.push_back(core_in_re_flat[k*W +: W]);
                    cap_im.push_back(core_in_im_flat[k*W +: W]);
                end
            end
            if (prev_stall && !(m_valid && m_re === prev_re && m_im === prev_im && m_idx === prev_idx))
                hold_viol++;
            if (s_ready === busy) inv_viol++;
            if (m_valid && (m_last !== (m_idx == 3'd7))) inv_viol++;
            if (m_valid && !prev_mv) mv_rise_q.push_back(cyc);
            if (m_valid && m_ready) begin
                out_re_q.push_back(m_re);
                out_im_q.push_back(m_im);
                out_idx_q.push_back(int'(m_idx));
                out_last_q.push_back(m_last);
                out_cyc_q.push_back(cyc);
            end
            prev_stall = m_valid && !m_ready;
            prev_mv    = m_valid;
            prev_re    = m_re;
            prev_im    = m_im;
            prev_idx   = m_idx;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rec();
        exp_re.delete(); exp_im.delete();
        start_cyc_q.delete(); cap_re.delete(); cap_im.delete();
        out_re_q.delete(); out_im_q.delete(); out_idx_q.delete();
        out_last_q.delete(); out_cyc_q.delete(); mv_rise_q.delete();
        tx_re.delete(); tx_im.delete();
        n_start = 0; n_acc = 0; hold_viol = 0; inv_viol = 0;
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) begin
            tx_re.push_back(W'($urandom));
            tx_im.push_back(W'($urandom));
        end
    endtask

    // gap: 0 = continuous, 1 = valid toggles 1/0, 2 = random valid
    task automatic send(input int base, input int n, input int gap, output int sent);
        int  guard = 0;
        bit  v;
        bit  acc;
        bit  ph = 1'b1;
        sent = 0;
        while (sent < n && guard < 500) begin
            case (gap)
                0:       v = 1'b1;
                1:       begin v = ph; ph = !ph; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            s_valid = v;
            s_re    = tx_re[base + sent];
            s_im    = tx_im[base + sent];
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            guard++;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n, input int budget, output bit ok);
        int g = 0;
        while (out_re_q.size() < n && g < budget) begin
            tick(1);
            g++;
        end
        ok = (out_re_q.size() >= n);
    endtask

    task automatic test_reset();
        s_valid = 1'b0;
        m_ready = 1'b1;
        rst_n   = 1'b0;
        tick(2);
        n_cmp++;
        if ({s_ready, m_valid, core_start, busy, err_timeout, m_idx, m_last} !== 9'b1_0000_000_0) begin
            n_err++;
            $display("FAIL reset_ctrl: got rdy=%b mv=%b st=%b busy=%b err=%b idx=%0d last=%b want 1 0 0 0 0 0 0",
                     s_ready, m_valid, core_start, busy, err_timeout, m_idx, m_last);
        end
        rst_n = 1'b1;
        tick(1);
        n_cmp++;
        if ({s_ready, m_valid, core_start, busy, err_timeout} !== 5'b1_0000) begin
            n_err++;
            $display("FAIL reset_release: got rdy=%b mv=%b st=%b busy=%b err=%b want 1 0 0 0 0",
                     s_ready, m_valid, core_start, busy, err_timeout);
        end
        n_cmp++;
        if (core_in_re_flat !== '0 || core_in_im_flat !== '0 || m_re !== '0 || m_im !== '0) begin
            n_err++;
            $display("FAIL reset_buffers: got in_re=%h in_im=%h m_re=%h m_im=%h want all 0",
                     core_in_re_flat, core_in_im_flat, m_re, m_im);
        end
    endtask

    task automatic test_cos_frame();
        int sent;
        bit ok;
        clear_rec();
        core_mode = 0;
        for (int i = 0; i < 8; i++) begin
            tx_re.push_back(W'(cosv[i]));
            tx_im.push_back('0);
        end
        send(0, 8, 0, sent);
        wait_outs(8, 100, ok);
        tick(3);
        n_cmp++;
        if (sent != 8 || ok !== 1'b1) begin
            n_err++;
            $display("FAIL cos_progress: got sent=%0d outs=%0d want 8 8", sent, out_re_q.size());
        end
        n_cmp++;
        if (n_start != 1 || start_cyc_q[0] != last_acc_cyc + 1) begin
            n_err++;
            $display("FAIL cos_start: got starts=%0d at cyc %0d want 1 at cyc %0d",
                     n_start, start_cyc_q[0], last_acc_cyc + 1);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (cap_re[k] !== tx_re[k] || cap_im[k] !== tx_im[k]) begin
                n_err++;
                $display("FAIL cos_lane%0d: got %h/%h want %h/%h", k, cap_re[k], cap_im[k], tx_re[k], tx_im[k]);
            end
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (out_re_q[k] !== exp_re[k] || out_im_q[k] !== exp_im[k] ||
                out_idx_q[k] != k || out_last_q[k] !== (k == 7)) begin
                n_err++;
                $display("FAIL cos_bin%0d: got %h/%h idx=%0d last=%b want %h/%h idx=%0d last=%b", k,
                         out_re_q[k], out_im_q[k], out_idx_q[k], out_last_q[k],
                         exp_re[k], exp_im[k], k, (k == 7));
            end
        end
        n_cmp++;
        if (mv_rise_q.size() != 1 || mv_rise_q[0] != done_cyc + 1 || out_cyc_q[7] - out_cyc_q[0] != 7) begin
            n_err++;
            $display("FAIL cos_latency: got first_mv=%0d span=%0d want first_mv=%0d span=7",
                     mv_rise_q[0], out_cyc_q[7] - out_cyc_q[0], done_cyc + 1);
        end
        n_cmp++;
        if (out_re_q.size() != 8 || s_ready !== 1'b1 || busy !== 1'b0 || inv_viol != 0) begin
            n_err++;
            $display("FAIL cos_end: got outs=%0d rdy=%b busy=%b inv=%0d want 8 1 0 0",
                     out_re_q.size(), s_ready, busy, inv_viol);
        end
    endtask

    task automatic test_backpressure();
        int sent;
        int stall_n = 0;
        int bad = 0;
        int g = 0;
        clear_rec();
        core_mode = 0;
        fill_rand(8);
        send(0, 8, 0, sent);
        while (out_re_q.size() < 8 && g < 200) begin
            if (m_valid && m_idx == 3'd3 && stall_n < 5) begin
                m_ready = 1'b0;
                stall_n++;
                if (s_ready !== 1'b0 || m_idx !== 3'd3) bad++;
            end else begin
                m_ready = 1'b1;
            end
            tick(1);
            g++;
        end
        m_ready = 1'b1;
        tick(4);
        n_cmp++;
        if (stall_n != 5 || bad != 0 || hold_viol != 0 || inv_viol != 0) begin
            n_err++;
            $display("FAIL bp_hold: got stalls=%0d bad=%0d hold=%0d inv=%0d want 5 0 0 0",
                     stall_n, bad, hold_viol, inv_viol);
        end
        n_cmp++;
        if (out_re_q.size() != 8) begin
            n_err++;
            $display("FAIL bp_count: got %0d bins want 8", out_re_q.size());
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (out_re_q[k] !== exp_re[k] || out_im_q[k] !== exp_im[k] || out_idx_q[k] != k) begin
                n_err++;
                $display("FAIL bp_bin%0d: got %h/%h idx=%0d want %h/%h idx=%0d", k,
                         out_re_q[k], out_im_q[k], out_idx_q[k], exp_re[k], exp_im[k], k);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sent;
        bit ok;
        clear_rec();
        core_mode = 0;
        fill_rand(16);
        for (int f = 0; f < 2; f++) begin
            send(f * 8, 8, f + 1, sent);
            tick(1);
            n_cmp++;
            if (sent != 8 || n_acc != 8 * (f + 1) || n_start != f + 1 ||
                start_cyc_q[f] != last_acc_cyc + 1) begin
                n_err++;
                $display("FAIL b2b_start%0d: got sent=%0d acc=%0d starts=%0d at %0d want 8 %0d %0d at %0d",
                         f, sent, n_acc, n_start, start_cyc_q[f], 8 * (f + 1), f + 1, last_acc_cyc + 1);
            end
            wait_outs(8 * (f + 1), 100, ok);
        end
        tick(3);
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (cap_re[i] !== tx_re[i] || cap_im[i] !== tx_im[i] ||
                out_re_q[i] !== exp_re[i] || out_im_q[i] !== exp_im[i] || out_idx_q[i] != i % 8) begin
                n_err++;
                $display("FAIL b2b_item%0d: got lane %h/%h bin %h/%h idx=%0d want lane %h/%h bin %h/%h idx=%0d",
                         i, cap_re[i], cap_im[i], out_re_q[i], out_im_q[i], out_idx_q[i],
                         tx_re[i], tx_im[i], exp_re[i], exp_im[i], i % 8);
            end
        end
        n_cmp++;
        if (out_re_q.size() != 16 || n_start != 2 || inv_viol != 0) begin
            n_err++;
            $display("FAIL b2b_totals: got bins=%0d starts=%0d inv=%0d want 16 2 0",
                     out_re_q.size(), n_start, inv_viol);
        end
    endtask

    task automatic test_sticky_done();
        int sent;
        bit ok;
        clear_rec();
        core_mode = 1;
        fill_rand(16);
        send(0, 8, 0, sent);
        wait_outs(8, 100, ok);
        tick(6);
        n_cmp++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || n_start != 1 || out_re_q.size() != 8) begin
            n_err++;
            $display("FAIL sticky_idle: got busy=%b mv=%b starts=%0d bins=%0d want 0 0 1 8",
                     busy, m_valid, n_start, out_re_q.size());
        end
        send(8, 8, 2, sent);
        wait_outs(16, 100, ok);
        tick(2);
        n_cmp++;
        if (ok !== 1'b1 || mv_rise_q.size() != 2 || mv_rise_q[1] != start_cyc_q[1] + 2) begin
            n_err++;
            $display("FAIL sticky_first_wait: got ok=%b rises=%0d rise=%0d want 1 2 %0d",
                     ok, mv_rise_q.size(), mv_rise_q[1], start_cyc_q[1] + 2);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (out_re_q[i] !== exp_re[i] || out_im_q[i] !== exp_im[i] || out_idx_q[i] != i % 8) begin
                n_err++;
                $display("FAIL sticky_bin%0d: got %h/%h idx=%0d want %h/%h idx=%0d", i,
                         out_re_q[i], out_im_q[i], out_idx_q[i], exp_re[i], exp_im[i], i % 8);
            end
        end
        core_mode = 0;
        tick(2);
    endtask

    task automatic test_mid_reset();
        int sent;
        int g = 0;
        bit ok;
        clear_rec();
        core_mode = 0;
        fill_rand(13);
        send(0, 5, 0, sent);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        n_cmp++;
        if (n_start != 0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mrst_partial: got starts=%0d rdy=%b busy=%b want 0 1 0", n_start, s_ready, busy);
        end
        send(5, 8, 0, sent);
        tick(1);
        n_cmp++;
        if (n_start != 1) begin
            n_err++;
            $display("FAIL mrst_start: got starts=%0d want 1", n_start);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (cap_re[k] !== tx_re[5 + k] || cap_im[k] !== tx_im[5 + k]) begin
                n_err++;
                $display("FAIL mrst_lane%0d: got %h/%h want %h/%h", k, cap_re[k], cap_im[k],
                         tx_re[5 + k], tx_im[5 + k]);
            end
        end
        wait_outs(8, 100, ok);
        tick(2);
        clear_rec();
        fill_rand(8);
        m_ready = 1'b0;
        send(0, 8, 0, sent);
        while (!m_valid && g < 100) begin
            tick(1);
            g++;
        end
        tick(2);
        rst_n = 1'b0;
        tick(1);
        n_cmp++;
        if (g >= 100 || m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mrst_unload: got wait=%0d mv=%b rdy=%b busy=%b want <100 0 1 0", g, m_valid, s_ready, busy);
        end
        m_ready = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(4);
        n_cmp++;
        if (out_re_q.size() != 0 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mrst_drop: got bins=%0d mv=%b want 0 0", out_re_q.size(), m_valid);
        end
    endtask

    task automatic test_wait_timeout();
        int sent;
        int s;
        int g = 0;
        bit ok;
        clear_rec();
        core_mode = 2;
        fill_rand(8);
        send(0, 8, 0, sent);
        tick(1);
        s = (start_cyc_q.size() > 0) ? start_cyc_q[0] : cyc;
`ifdef FFT8_SEQ_TIMEOUT_EN
        while (cyc < s + TO && g < 200) begin
            tick(1);
            g++;
        end
        n_cmp++;
        if (busy !== 1'b1 || err_timeout !== 1'b0 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL to_last_wait: got busy=%b err=%b mv=%b want 1 0 0", busy, err_timeout, m_valid);
        end
        tick(1);
        n_cmp++;
        if (busy !== 1'b0 || s_ready !== 1'b1 || err_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL to_abort: got busy=%b rdy=%b err=%b want 0 1 1", busy, s_ready, err_timeout);
        end
        tick(5);
        n_cmp++;
        if (mv_rise_q.size() != 0 || out_re_q.size() != 0) begin
            n_err++;
            $display("FAIL to_no_output: got rises=%0d bins=%0d want 0 0", mv_rise_q.size(), out_re_q.size());
        end
        clear_rec();
        core_mode = 0;
        fill_rand(8);
        send(0, 8, 0, sent);
`else
        tick(100);
        n_cmp++;
        if (busy !== 1'b1 || s_ready !== 1'b0 || err_timeout !== 1'b0 || mv_rise_q.size() != 0) begin
            n_err++;
            $display("FAIL wait_hold: got busy=%b rdy=%b err=%b rises=%0d want 1 0 0 0",
                     busy, s_ready, err_timeout, mv_rise_q.size());
        end
        core_mode  = 0;
        force_done = 1'b1;
`endif
        wait_outs(8, 100, ok);
        tick(2);
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (out_re_q[k] !== exp_re[k] || out_im_q[k] !== exp_im[k] || out_idx_q[k] != k) begin
                n_err++;
                $display("FAIL wait_bin%0d: got %h/%h idx=%0d want %h/%h idx=%0d", k,
                         out_re_q[k], out_im_q[k], out_idx_q[k], exp_re[k], exp_im[k], k);
            end
        end
        n_cmp++;
`ifdef FFT8_SEQ_TIMEOUT_EN
        if (err_timeout !== 1'b1 || ok !== 1'b1) begin
            n_err++;
            $display("FAIL to_sticky: got err=%b ok=%b want 1 1", err_timeout, ok);
        end
`else
        if (err_timeout !== 1'b0 || ok !== 1'b1) begin
            n_err++;
            $display("FAIL wait_err: got err=%b ok=%b want 0 1", err_timeout, ok);
        end
`endif
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation still running at %0t want finished", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cos_frame();
        test_backpressure();
        test_back_to_back();
        test_sticky_done();
        test_mid_reset();
        test_wait_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
